// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared state encoding and magnitude helper for seq_mul_hs
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // |x| of the low w bits of x; x[w-1] is the sign when signed_en is set.
  function automatic logic [63:0] mag(input logic [63:0] x, input int unsigned w,
                                      input logic signed_en);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (signed_en && (((x >> (w - 1)) & 64'd1) != 64'd0))
      return (~x + 64'd1) & mask;
    return x & mask;
  endfunction

endpackage

// File: rtl/seq_mul_hs.sv
// rtl/seq_mul_hs.sv - shift-and-add multiplier with valid/ready operand and result handshakes
module seq_mul_hs
  import seq_mul_pkg::*;
#(
  parameter int WA = 8,
  parameter int WB = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  input  logic             is_signed,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WA+WB-1:0] result
);

  localparam int WP = WA + WB;

  state_t        state, state_n;
  logic [WP-1:0] acc, acc_n;
  logic [WP-1:0] ma, ma_n;
  logic [WB-1:0] mb, mb_n;
  logic          neg, neg_n;
  logic [WA-1:0] a_mag;
  logic [WB-1:0] b_mag;

  // Magnitudes of the most negative values still fit in the unsigned widths.
  assign a_mag = WA'(mag(64'(a), WA, is_signed));
  assign b_mag = WB'(mag(64'(b), WB, is_signed));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      ma    <= '0;
      mb    <= '0;
      neg   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      ma    <= ma_n;
      mb    <= mb_n;
      neg   <= neg_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    ma_n    = ma;
    mb_n    = mb;
    neg_n   = neg;
    case (state)
      IDLE: begin
        if (in_valid) begin
          ma_n    = WP'(a_mag);
          mb_n    = b_mag;
          acc_n   = '0;
          neg_n   = is_signed & (a[WA-1] ^ b[WB-1]);
          state_n = (b_mag != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          if (mb[0]) acc_n = acc + ma;
          ma_n = ma << 1;
          mb_n = mb >> 1;
          // Early exit: stop as soon as no multiplier bits remain.
          if (mb_n == '0) state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = out_valid ? (neg ? -acc : acc) : '0;

endmodule
